instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one memory read per pc change, latches the
// instruction and resolves relative branches for the program counter.
module instr_fetch #(
  parameter logic [5:0] BR_OPC  = 6'b000100,
  parameter logic [5:0] BZ_OPC  = 6'b000101,
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        zero_flag,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        branch,
  output logic [15:0] offset,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESOLVE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] last_pc_reg, last_pc_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        mem_req_reg, mem_req_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] instr_reg, instr_next;
  logic        instr_valid_reg, instr_valid_next;
  logic        branch_reg, branch_next;
  logic [15:0] offset_reg, offset_next;
  logic        fetch_err_reg, fetch_err_next;
  logic        take_branch;

  assign take_branch = (instr_reg[31:26] == BR_OPC) ||
                       ((instr_reg[31:26] == BZ_OPC) && zero_flag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      last_pc_reg     <= 32'hFFFF_FFFF;
      cnt_reg         <= 8'd0;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= 32'd0;
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      branch_reg      <= 1'b0;
      offset_reg      <= 16'd0;
      fetch_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      last_pc_reg     <= last_pc_next;
      cnt_reg         <= cnt_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      branch_reg      <= branch_next;
      offset_reg      <= offset_next;
      fetch_err_reg   <= fetch_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_pc_next     = last_pc_reg;
    cnt_next         = cnt_reg;
    mem_req_next     = mem_req_reg;
    mem_addr_next    = mem_addr_reg;
    instr_next       = instr_reg;
    instr_valid_next = 1'b0;
    branch_next      = branch_reg;
    offset_next      = offset_reg;
    fetch_err_next   = fetch_err_reg;

    case (state_reg)
      IDLE: begin
        if (pc != last_pc_reg) begin
          last_pc_next = pc;
          // A misaligned pc never reaches memory; it completes as a NOP with an error.
          if (pc[1:0] != 2'b00) begin
            fetch_err_next   = 1'b1;
            instr_next       = 32'd0;
            instr_valid_next = 1'b1;
            state_next       = RESOLVE;
          end else begin
            mem_req_next  = 1'b1;
            mem_addr_next = {pc[31:2], 2'b00};
            state_next    = REQ;
          end
        end
      end
      REQ: begin
        // Read data arriving with the grant is not accepted yet.
        if (mem_gnt) begin
          mem_req_next = 1'b0;
          cnt_next     = 8'd0;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          instr_next       = mem_rdata;
          instr_valid_next = 1'b1;
          state_next       = RESOLVE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == TIMEOUT - 8'd1) begin
            fetch_err_next   = 1'b1;
            instr_next       = 32'd0;
            instr_valid_next = 1'b1;
            state_next       = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        branch_next = take_branch;
        offset_next = take_branch ? instr_reg[15:0] : 16'd0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign branch      = branch_reg;
  assign offset      = offset_reg;
  assign fetch_err   = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch results are queued when the
// memory response (or error condition) is driven and checked on instr_valid.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        zero_flag;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        branch;
  logic [15:0] offset;
  logic        fetch_err;

  instr_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .zero_flag(zero_flag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr(instr),
    .instr_valid(instr_valid), .branch(branch), .offset(offset),
    .fetch_err(fetch_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        br;
    logic [15:0] off;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_seen = 0;
  int   valid_exp = 0;
  logic err_exp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference behaviour of a completed fetch, independent of the DUT.
  task automatic push_exp(input logic [31:0] rd, input logic zf, input logic is_err);
    exp_t e;
    logic [5:0] op;
    if (is_err) err_exp = 1'b1;
    e.instr = is_err ? 32'd0 : rd;
    op      = e.instr[31:26];
    e.br    = (op == 6'b000100) || ((op == 6'b000101) && zf);
    e.off   = e.br ? e.instr[15:0] : 16'd0;
    e.err   = err_exp;
    sb.push_back(e);
    valid_exp++;
  endtask

  // Monitor: one line per completed fetch.
  exp_t        cur;
  logic        chk_br = 1'b0;
  logic        held_br = 1'b0;
  logic [15:0] held_off = 16'd0;
  always @(negedge clk) begin
    if (!rst) begin
      held_br  = 1'b0;
      held_off = 16'd0;
      chk_br   = 1'b0;
    end else begin
      if (chk_br) begin
        check("branch", {31'd0, branch}, {31'd0, cur.br});
        check("offset", {16'd0, offset}, {16'd0, cur.off});
        held_br  = cur.br;
        held_off = cur.off;
        chk_br   = 1'b0;
      end
      if (instr_valid) begin
        valid_seen++;
        check("branch_hold", {31'd0, branch}, {31'd0, held_br});
        check("offset_hold", {16'd0, offset}, {16'd0, held_off});
        if (sb.size() == 0) begin
          check("spurious_valid", {31'd0, instr_valid}, 32'd0);
        end else begin
          cur = sb.pop_front();
          check("instr", instr, cur.instr);
          check("fetch_err", {31'd0, fetch_err}, {31'd0, cur.err});
          chk_br = 1'b1;
          $display("fetch: instr=%h err=%0b exp_branch=%0b exp_offset=%h", instr, fetch_err, cur.br, cur.off);
        end
      end
    end
  end

  task automatic wait_req(input logic [31:0] addr);
    for (int i = 0; i < 8 && !mem_req; i++) tick();
    check("req_seen", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, addr);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] rd, input int gd,
                       input int rdly, input logic zf, input logic rv_at_gnt);
    pc = a;
    zero_flag = zf;
    wait_req(a);
    repeat (gd) begin
      tick();
      check("req_hold", {31'd0, mem_req}, 32'd1);
      check("addr_hold", mem_addr, a);
    end
    mem_gnt = 1'b1;
    mem_rvalid = rv_at_gnt;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    check("req_drop", {31'd0, mem_req}, 32'd0);
    check("no_early_valid", {31'd0, instr_valid}, 32'd0);
    repeat (rdly) tick();
    push_exp(rd, zf, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
    check("valid_pulse", {31'd0, instr_valid}, 32'd1);
    tick();
    check("valid_one_cycle", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    err_exp = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_branch", {31'd0, branch}, 32'd0);
    check("rst_offset", {16'd0, offset}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rnd;
    logic [5:0]  op;
    pc = 32'd0;
    zero_flag = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    rst = 1'b0;
    tick();
    do_reset();
    check_reset_outputs();
    rst = 1'b1;

    // Basic, unconditional branch, conditional branch with both zero_flag values.
    fetch(32'h0000_0000, 32'h0000_1234, 0, 0, 1'b0, 1'b0);
    fetch(32'h0000_0004, {6'b000100, 10'd0, 16'hFFF8}, 1, 2, 1'b0, 1'b0);
    fetch(32'h0000_0008, {6'b000101, 10'd0, 16'h0010}, 0, 1, 1'b0, 1'b0);
    fetch(32'h0000_000C, {6'b000101, 10'd0, 16'h0010}, 2, 0, 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rnd = $urandom;
      op = 6'($urandom_range(3, 6));
      fetch(32'h0000_0100 + 32'(i * 4), {op, rnd[25:0]}, int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Timeout: grant, then 64 WAIT cycles without read data.
    pc = 32'h0000_0040;
    wait_req(32'h0000_0040);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    push_exp(32'd0, zero_flag, 1'b1);
    repeat (63) tick();
    check("timeout_not_early", {31'd0, instr_valid}, 32'd0);
    tick();
    check("timeout_pulse", {31'd0, instr_valid}, 32'd1);
    repeat (3) tick();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1111_2222;
    repeat (2) tick();
    mem_rvalid = 1'b0;
    check("late_rvalid_instr", instr, 32'd0);
    check("err_sticky", {31'd0, fetch_err}, 32'd1);

    // Misaligned pc straight out of reset.
    pc = 32'h0000_0006;
    do_reset();
    push_exp(32'd0, zero_flag, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("misaligned_no_req", {31'd0, mem_req}, 32'd0);
    end
    check("misaligned_err", {31'd0, fetch_err}, 32'd1);

    // Reset in WAIT, then read data that must be discarded.
    do_reset();
    rst = 1'b1;
    pc = 32'h0000_0020;
    wait_req(32'h0000_0020);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs();
    mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    check("rst_discard_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_discard_instr", instr, 32'd0);
    mem_rvalid = 1'b0;
    err_exp = 1'b0;
    rst = 1'b1;
    fetch(32'h0000_0020, 32'h0000_7777, 0, 1, 1'b0, 1'b0);

    repeat (4) tick();
    check("valid_count", valid_seen, valid_exp);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
